// File: rtl/gpout_tx_if.sv
// Character-write handshake plus the 16-bit GPIO word seen by the tester.
interface gpout_tx_if;
   logic        wr_valid;
   logic [7:0]  wr_data;
   logic        wr_ready;
   logic        fin_req;
   logic [15:0] GPOUT;

   modport master (output wr_valid, wr_data, fin_req, input wr_ready, GPOUT);
   modport slave  (input wr_valid, wr_data, fin_req, output wr_ready, GPOUT);
endinterface

// File: rtl/gpout_tx.sv
// Character FIFO feeding a strobed GPIO word; byte accepted at edge N strobes after edge N+1.
// wr_ready drops while the FIFO is full or once a finish is pending; GPOUT is fully registered.
module gpout_tx #(
   parameter int DEPTH = 8,
   parameter int GAP   = 1
) (
   input  logic CLK,
   input  logic RSTn,
   gpout_tx_if.slave bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [2:0] {S_IDLE, S_STROBE, S_GAP, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [4:0] zero;
      logic       fin;
      logic       busy;
      logic       stb;
      logic [7:0] dat;
   } gpout_t;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_cnt;
   logic [AW:0]   w_cnt_nxt;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_gcnt;
   logic          r_fin;
   logic          r_live;
   gpout_t        r_gp;
   gpout_t        w_gp_nxt;
   logic          w_empty;
   logic          w_full;
   logic          w_rdy;
   logic          w_push;
   logic          w_pop;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == (AW+1)'(DEPTH));
   // r_live keeps wr_ready low until the first edge after reset release
   assign w_rdy   = r_live & ~w_full & ~r_fin;
   assign w_push  = bus.wr_valid & w_rdy;

   assign bus.wr_ready = w_rdy;
   assign bus.GPOUT    = r_gp;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_fin)
               w_state_nxt = S_DRAIN;
            else if (!w_empty)
               w_state_nxt = S_STROBE;
         end
         S_STROBE: begin
            if (GAP > 0)
               w_state_nxt = S_GAP;
            else if (!w_empty)
               w_state_nxt = S_STROBE;
            else if (r_fin)
               w_state_nxt = S_DONE;
            else
               w_state_nxt = S_IDLE;
         end
         S_GAP: begin
            if (r_gcnt == 4'd0) begin
               if (!r_fin)
                  w_state_nxt = S_IDLE;
               else if (w_empty)
                  w_state_nxt = S_DONE;
               else
                  w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: w_state_nxt = w_empty ? S_DONE : S_STROBE;
         S_DONE:  w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase

      // Every entry into STROBE consumes the FIFO head on that same edge
      w_pop = (w_state_nxt == S_STROBE);

      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop)
         w_cnt_nxt = r_cnt + 1'b1;
      else if (!w_push && w_pop)
         w_cnt_nxt = r_cnt - 1'b1;

      w_gp_nxt      = r_gp;
      w_gp_nxt.zero = '0;
      w_gp_nxt.stb  = w_pop;
      if (w_pop)
         w_gp_nxt.dat = r_mem[r_rptr];
      w_gp_nxt.busy = (w_cnt_nxt != '0) || !(w_state_nxt inside {S_IDLE, S_DONE});
      w_gp_nxt.fin  = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state <= S_IDLE;
         r_gcnt  <= '0;
         r_fin   <= 1'b0;
         r_live  <= 1'b0;
         r_gp    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
         r_gp    <= w_gp_nxt;
         if (bus.fin_req)
            r_fin <= 1'b1;
         if (r_state == S_STROBE && w_state_nxt == S_GAP)
            r_gcnt <= GAP_LD;
         else if (r_state == S_GAP && r_gcnt != 4'd0)
            r_gcnt <= r_gcnt - 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         r_cnt <= w_cnt_nxt;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push)
         r_mem[r_wptr] <= bus.wr_data;
   end

endmodule

// File: tb/tb_gpout_tx.sv
// Bench for gpout_tx: three configurations (8/1, 8/0, 4/2) under a shared reset and a queue-style model.
module tb_gpout_tx;

   logic        CLK  = 1'b0;
   logic        RSTn = 1'b1;
   logic        v   [3];
   logic [7:0]  d   [3];
   logic        f   [3];
   logic        rdy [3];
   logic [15:0] gp  [3];

   always #5 CLK = ~CLK;

   gpout_tx_if bus0();
   gpout_tx_if bus1();
   gpout_tx_if bus2();

   assign bus0.wr_valid = v[0];
   assign bus0.wr_data  = d[0];
   assign bus0.fin_req  = f[0];
   assign bus1.wr_valid = v[1];
   assign bus1.wr_data  = d[1];
   assign bus1.fin_req  = f[1];
   assign bus2.wr_valid = v[2];
   assign bus2.wr_data  = d[2];
   assign bus2.fin_req  = f[2];
   assign rdy[0] = bus0.wr_ready;
   assign rdy[1] = bus1.wr_ready;
   assign rdy[2] = bus2.wr_ready;
   assign gp[0]  = bus0.GPOUT;
   assign gp[1]  = bus1.GPOUT;
   assign gp[2]  = bus2.GPOUT;

   gpout_tx #(.DEPTH(8), .GAP(1)) u0 (.CLK(CLK), .RSTn(RSTn), .bus(bus0));
   gpout_tx #(.DEPTH(8), .GAP(0)) u1 (.CLK(CLK), .RSTn(RSTn), .bus(bus1));
   gpout_tx #(.DEPTH(4), .GAP(2)) u2 (.CLK(CLK), .RSTn(RSTn), .bus(bus2));

   int errors = 0;
   int checks = 0;
   int stalls = 0;

   // Reference model: per instance, the list of accepted bytes and how many have been strobed
   logic [7:0] m_dat [3][256];
   int  m_acc [3];
   int  m_str [3];
   int  m_since [3];
   int  m_run [3];
   int  m_maxrun [3];
   int  m_maxocc [3];
   bit  m_fin [3];
   bit  m_had [3];
   bit  m_prev_rst = 1'b0;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        f;
      logic [15:0] gp;
      logic        rdy;
   } vec_t;
   vec_t tbl [13];

   function automatic int dep_of(int k);
      return (k == 2) ? 4 : 8;
   endfunction

   function automatic int gap_of(int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0;
         f[k] = 1'b0;
      end
      step();
      step();
      RSTn = 1'b1;
   endtask

   task automatic monitor();
      bit live;
      bit exp_rdy;
      int occ;
      forever begin
         @(negedge CLK);
         live = m_prev_rst;
         for (int k = 0; k < 3; k++) begin
            if (!RSTn) begin
               m_acc[k] = 0; m_str[k] = 0; m_since[k] = 0; m_run[k] = 0;
               m_maxrun[k] = 0; m_maxocc[k] = 0; m_fin[k] = 1'b0; m_had[k] = 1'b0;
               check("reset_gpout", 32'(gp[k]), 32'h0);
               check("reset_ready", 32'(rdy[k]), 32'h0);
            end else begin
               if (gp[k][8]) begin
                  check("strobe_backlog", 32'(m_acc[k] > m_str[k]), 32'h1);
                  if (m_acc[k] > m_str[k])
                     check("strobe_data", 32'(gp[k][7:0]), 32'(m_dat[k][m_str[k] % 256]));
                  if (m_had[k])
                     check("strobe_spacing", 32'(m_since[k] >= gap_of(k)), 32'h1);
                  m_had[k] = 1'b1;
                  m_since[k] = 0;
                  m_str[k]++;
                  m_run[k]++;
                  if (m_run[k] > m_maxrun[k]) m_maxrun[k] = m_run[k];
               end else begin
                  m_since[k]++;
                  m_run[k] = 0;
               end
               check("fin_stb_excl", 32'(gp[k][10] & gp[k][8]), 32'h0);
               check("zero_bits", 32'(gp[k][15:11]), 32'h0);
               occ = m_acc[k] - m_str[k];
               if (occ > m_maxocc[k]) m_maxocc[k] = occ;
               exp_rdy = live && (occ < dep_of(k)) && !m_fin[k];
               check("ready", 32'(rdy[k]), 32'(exp_rdy));
               if (v[k] && rdy[k]) begin
                  m_dat[k][m_acc[k] % 256] = d[k];
                  m_acc[k]++;
               end
               if (f[k]) m_fin[k] = 1'b1;
            end
         end
         m_prev_rst = RSTn;
      end
   endtask

   task automatic push(int k, logic [7:0] b);
      bit ok = 1'b0;
      v[k] = 1'b1;
      d[k] = b;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge CLK);
         if (rdy[k]) ok = 1'b1;
         else stalls++;
         step();
      end
      check("push_accepted", 32'(ok), 32'h1);
   endtask

   task automatic wait_drain(int k);
      for (int t = 0; t < 400 && m_str[k] < m_acc[k]; t++)
         step();
      step();
      check("drained", 32'(m_str[k]), 32'(m_acc[k]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      int last_stb;
      int fin_at;
      int sent [3];
      bit hs [3];
      bit busy_any;

      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0; d[k] = 8'h00; f[k] = 1'b0;
      end
      tbl[0]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0};
      tbl[1]  = '{1'b1, 8'h41, 1'b0, 16'h0000, 1'b1};
      tbl[2]  = '{1'b0, 8'h00, 1'b0, 16'h0200, 1'b1};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 16'h0341, 1'b1};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 16'h0241, 1'b1};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 16'h0041, 1'b1};
      tbl[6]  = '{1'b1, 8'h5A, 1'b0, 16'h0041, 1'b1};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 16'h0241, 1'b1};
      tbl[8]  = '{1'b1, 8'h77, 1'b0, 16'h035A, 1'b0};
      tbl[9]  = '{1'b1, 8'h77, 1'b0, 16'h025A, 1'b0};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 16'h045A, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 16'h045A, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b0, 16'h045A, 1'b0};

      fork
         monitor();
      join_none

      // Single character, then a finish with one more byte queued
      #1;
      do_reset();
      for (int i = 0; i < 13; i++) begin
         v[0] = tbl[i].v;
         d[0] = tbl[i].d;
         f[0] = tbl[i].f;
         @(negedge CLK);
         check($sformatf("tbl%0d_gpout", i), 32'(gp[0]), 32'(tbl[i].gp));
         check($sformatf("tbl%0d_ready", i), 32'(rdy[0]), 32'(tbl[i].rdy));
         step();
      end
      v[0] = 1'b0;

      // Finish with three bytes pending
      do_reset();
      step();
      push(0, 8'hA1);
      push(0, 8'hB2);
      push(0, 8'hC3);
      v[0] = 1'b0;
      f[0] = 1'b1;
      step();
      f[0] = 1'b0;
      last_stb = -1;
      fin_at = -1;
      for (int t = 0; t < 60 && fin_at < 0; t++) begin
         @(negedge CLK);
         if (gp[0][8]) last_stb = t;
         if (gp[0][10]) fin_at = t;
         step();
      end
      check("fin_seen", 32'(fin_at >= 0), 32'h1);
      check("fin_after_gap", 32'(fin_at - last_stb), 32'd2);
      v[0] = 1'b1;
      d[0] = 8'hEE;
      repeat (3) step();
      v[0] = 1'b0;
      @(negedge CLK);
      check("fin_strobes", 32'(m_str[0]), 32'd3);
      check("done_word", 32'(gp[0]), 32'h04C3);

      // Back-to-back burst with no gap
      do_reset();
      step();
      for (int i = 0; i < 8; i++) push(1, 8'(i));
      v[1] = 1'b0;
      wait_drain(1);
      check("burst_count", 32'(m_str[1]), 32'd8);
      check("burst_run", 32'(m_maxrun[1]), 32'd8);

      // Overflow: nine pushes into a four-deep FIFO must stall, not drop
      do_reset();
      step();
      stalls = 0;
      for (int i = 0; i < 9; i++) push(2, 8'(8'h30 + i));
      v[2] = 1'b0;
      check("overflow_stalled", 32'(stalls > 0), 32'h1);
      wait_drain(2);
      check("overflow_count", 32'(m_str[2]), 32'd9);
      check("overflow_maxocc", 32'(m_maxocc[2]), 32'd4);

      // Asynchronous reset during the second strobe
      do_reset();
      step();
      for (int i = 0; i < 4; i++) push(0, 8'(8'h60 + i));
      v[0] = 1'b0;
      seen = 0;
      for (int t = 0; t < 60 && seen < 2; t++) begin
         @(negedge CLK);
         if (gp[0][8]) seen++;
      end
      check("second_strobe_seen", 32'(seen), 32'd2);
      #1;
      RSTn = 1'b0;
      #1;
      check("async_gpout0", 32'(gp[0]), 32'h0);
      check("async_ready0", 32'(rdy[0]), 32'h0);
      step();
      step();
      RSTn = 1'b1;
      seen = 0;
      busy_any = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge CLK);
         if (gp[0][8]) seen++;
         if (gp[0][9]) busy_any = 1'b1;
      end
      check("post_reset_strobes", 32'(seen), 32'd0);
      check("post_reset_busy", 32'(busy_any), 32'h0);
      step();

      // Random streams into all three instances with random valid gaps
      do_reset();
      step();
      for (int k = 0; k < 3; k++) sent[k] = 0;
      for (int t = 0; t < 3000 && (sent[0] < 20 || sent[1] < 20 || sent[2] < 20); t++) begin
         @(negedge CLK);
         for (int k = 0; k < 3; k++) hs[k] = v[k] & rdy[k];
         step();
         for (int k = 0; k < 3; k++) begin
            if (hs[k]) begin
               sent[k]++;
               v[k] = 1'b0;
            end
            if (!v[k] && sent[k] < 20 && $urandom_range(0, 2) != 0) begin
               v[k] = 1'b1;
               d[k] = 8'($urandom);
            end
         end
      end
      for (int k = 0; k < 3; k++) v[k] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rand_sent%0d", k), 32'(sent[k]), 32'd20);
         wait_drain(k);
         check($sformatf("rand_strobes%0d", k), 32'(m_str[k]), 32'd20);
      end
      check("wrap_maxocc_le4", 32'(m_maxocc[2] <= 4), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
